// File: rtl/crop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pkg
//  Description : Shared types and helpers for the crop / uncrop pixel paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package crop_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int FRAME_ROWS_DEF = 20;
    localparam int FRAME_COLS_DEF = 20;

    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W_DEF = coord_width(FRAME_ROWS_DEF);
    localparam int COL_W_DEF = coord_width(FRAME_COLS_DEF);

    function automatic int unsigned clamp_coord(input int unsigned v, input int unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uncrop_pad_if.sv
`default_nettype none
// ============================================================================
//  Module      : uncrop_pad_if
//  Description : Pixel stream bundle (valid/ready, data, end-of-row, start-of-frame).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uncrop_pad_if #(
    parameter int DW = 10
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/uncrop_pad_coord.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_coord_counter
//  Description : Raster row/column counter with end-of-row and end-of-frame flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_coord_counter #(
    parameter int ROWS  = 20,
    parameter int COLS  = 20,
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic             i_advance,
    output logic      [ROW_W-1:0] o_row,
    output logic      [COL_W-1:0] o_col,
    output logic                  o_eor,
    output logic                  o_eof
);
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_eor;
    logic             w_eof;

    assign w_eor = (r_col == COL_W'(COLS - 1));
    assign w_eof = w_eor && (r_row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_eor) begin
                r_col <= '0;
                r_row <= w_eof ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;
    assign o_eor = w_eor;
    assign o_eof = w_eof;
endmodule
`default_nettype wire

// File: rtl/uncrop_pad.sv
`default_nettype none
// ============================================================================
//  Module      : uncrop_pad
//  Description : Re-embeds a streamed crop into a full raster frame, padding the rest.
//  Revision    : 1.0 - initial release
// ============================================================================
module uncrop_pad
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int CROP_ROWS       = 10,
    parameter int CROP_COLS       = 10,
    parameter int FRAME_ROWS      = 20,
    parameter int FRAME_COLS      = 20,
    localparam int XW             = coord_width(FRAME_COLS),
    localparam int YW             = coord_width(FRAME_ROWS)
) (
    input  wire logic                       clk,
    input  wire logic                       s_axis_resetn,
    input  wire logic                       ap_start,
    output logic                            ap_ready,
    output logic                            ap_done,
    input  wire logic [XW-1:0]              crop_x0,
    input  wire logic [YW-1:0]              crop_y0,
    input  wire logic [PIXEL_BIT_WIDTH-1:0] pad_value,
    uncrop_pad_if.slave                     s_axis,
    uncrop_pad_if.master                    m_axis
);
    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [XW-1:0]              r_x0;
    logic [YW-1:0]              r_y0;
    logic [PIXEL_BIT_WIDTH-1:0] r_pad;
    logic                       r_all_loaded;
    logic                       r_tvalid;
    logic [PIXEL_BIT_WIDTH-1:0] r_tdata;
    logic                       r_tlast;
    logic                       r_tuser;

    logic [YW-1:0] w_row;
    logic [XW-1:0] w_col;
    logic          w_eor, w_eof;
    logic          w_start, w_final, w_slot, w_inside, w_load;
    logic [XW:0]   w_col_e, w_x_lo, w_x_hi;
    logic [YW:0]   w_row_e, w_y_lo, w_y_hi;
    logic          w_unused_sideband;

    assign w_unused_sideband = s_axis.tlast ^ s_axis.tuser;

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) r_state <= ST_IDLE;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            ST_IDLE: if (ap_start) begin
                w_start     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: if (r_all_loaded && r_tvalid && m_axis.tready) begin
                w_final     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign ap_ready = (r_state == ST_IDLE) || w_final;
    assign ap_done  = w_final;

    // Window bounds are one bit wider so x0+CROP_COLS never wraps.
    assign w_col_e  = {1'b0, w_col};
    assign w_x_lo   = {1'b0, r_x0};
    assign w_x_hi   = w_x_lo + (XW+1)'(CROP_COLS);
    assign w_row_e  = {1'b0, w_row};
    assign w_y_lo   = {1'b0, r_y0};
    assign w_y_hi   = w_y_lo + (YW+1)'(CROP_ROWS);
    assign w_inside = (w_row_e >= w_y_lo) && (w_row_e < w_y_hi) &&
                      (w_col_e >= w_x_lo) && (w_col_e < w_x_hi);

    assign w_slot        = (r_state == ST_RUN) && !r_all_loaded && (!r_tvalid || m_axis.tready);
    assign w_load        = w_slot && (!w_inside || s_axis.tvalid);
    assign s_axis.tready = w_slot && w_inside;

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_x0         <= '0;
            r_y0         <= '0;
            r_pad        <= '0;
            r_all_loaded <= 1'b0;
        end else if (w_start) begin
            r_x0         <= XW'(clamp_coord(32'(crop_x0), FRAME_COLS - CROP_COLS));
            r_y0         <= YW'(clamp_coord(32'(crop_y0), FRAME_ROWS - CROP_ROWS));
            r_pad        <= pad_value;
            r_all_loaded <= 1'b0;
        end else if (w_load && w_eof) begin
            r_all_loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_inside ? s_axis.tdata : r_pad;
            r_tlast  <= w_eor;
            r_tuser  <= (w_row == '0) && (w_col == '0);
        end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tuser  = r_tuser;

    pixel_coord_counter #(
        .ROWS  (FRAME_ROWS),
        .COLS  (FRAME_COLS),
        .ROW_W (YW),
        .COL_W (XW)
    ) u_coord (
        .clk       (clk),
        .rst_n     (s_axis_resetn),
        .i_clear   (w_start),
        .i_advance (w_load),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_eor     (w_eor),
        .o_eof     (w_eof)
    );
endmodule
`default_nettype wire

// File: tb/tb_uncrop_pad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uncrop_pad
//  Description : Self-checking bench for uncrop_pad against a raster-placement model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uncrop_pad;
    localparam int PW = 10;
    localparam int FR = 4;
    localparam int FC = 4;
    localparam int CR = 2;
    localparam int CC = 2;
    localparam int N  = FR * FC;
    localparam int NI = CR * CC;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic [1:0]    crop_x0;
    logic [1:0]    crop_y0;
    logic [PW-1:0] pad_value;

    uncrop_pad_if #(.DW(PW)) s_if ();
    uncrop_pad_if #(.DW(PW)) m_if ();

    uncrop_pad #(
        .PIXEL_BIT_WIDTH (PW),
        .CROP_ROWS       (CR),
        .CROP_COLS       (CC),
        .FRAME_ROWS      (FR),
        .FRAME_COLS      (FC)
    ) dut (
        .clk           (clk),
        .s_axis_resetn (rstn),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .crop_x0       (crop_x0),
        .crop_y0       (crop_y0),
        .pad_value     (pad_value),
        .s_axis        (s_if),
        .m_axis        (m_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] in_pix   [NI];
    logic [PW-1:0] exp_data [N];
    logic          exp_last [N];
    logic          exp_user [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_model(input int cx, input int cy, input logic [PW-1:0] pad);
        int x0, y0, k;
        x0 = (cx > FC - CC) ? FC - CC : cx;
        y0 = (cy > FR - CR) ? FR - CR : cy;
        k  = 0;
        for (int r = 0; r < FR; r++) begin
            for (int c = 0; c < FC; c++) begin
                if (r >= y0 && r < y0 + CR && c >= x0 && c < x0 + CC) begin
                    exp_data[r*FC+c] = in_pix[k];
                    k++;
                end else begin
                    exp_data[r*FC+c] = pad;
                end
                exp_last[r*FC+c] = (c == FC - 1);
                exp_user[r*FC+c] = (r == 0 && c == 0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, m_if.tvalid, 0);
        check_eq({tag, "_tdata"},  m_if.tdata, 0);
        check_eq({tag, "_tlast"},  m_if.tlast, 0);
        check_eq({tag, "_tuser"},  m_if.tuser, 0);
        check_eq({tag, "_ready"},  ap_ready, 1);
        check_eq({tag, "_done"},   ap_done, 0);
        check_eq({tag, "_stready"}, s_if.tready, 0);
    endtask

    task automatic run_frame(input int cx, input int cy, input logic [PW-1:0] pad,
                             input bit rnd_m, input bit rnd_s, input int gap_at,
                             input bit midstart, input int rst_at, input bit chk_lat);
        int cyc, in_idx, out_idx, dones, first, done_cyc, gap;
        bit stall_prev, s_hold;
        logic [PW+1:0] held;
        build_model(cx, cy, pad);
        @(negedge clk);
        crop_x0 = 2'(cx); crop_y0 = 2'(cy); pad_value = pad;
        ap_start = 1'b1; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
        #1;
        check_eq("ready_idle", ap_ready, 1);
        @(negedge clk);
        ap_start  = 1'b0;
        crop_x0   = 2'($urandom); crop_y0 = 2'($urandom);
        pad_value = PW'($urandom);
        cyc = 1; in_idx = 0; out_idx = 0; dones = 0; first = -1; done_cyc = -1;
        gap = 0; stall_prev = 0; s_hold = 0; held = '0;
        while (out_idx < N && cyc < 1000) begin
            m_if.tready = rnd_m ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_idx >= NI) s_if.tvalid = 1'b0;
            else if (s_hold) s_if.tvalid = 1'b1;
            else if (gap_at == in_idx && gap < 5) begin s_if.tvalid = 1'b0; gap++; end
            else s_if.tvalid = rnd_s ? 1'($urandom_range(0, 1)) : 1'b1;
            s_if.tdata = (in_idx < NI) ? in_pix[in_idx] : PW'($urandom);
            if (midstart) begin
                ap_start = (out_idx >= 5 && out_idx < 8);
                crop_x0  = 2'(cx + 1);
            end
            #1;
            if (m_if.tvalid && first < 0) first = cyc;
            if (stall_prev)
                check_eq("stall_hold", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, held});
            s_hold = s_if.tvalid && !s_if.tready;
            if (s_if.tvalid && s_if.tready) in_idx++;
            if (ap_done) begin dones++; done_cyc = cyc; end
            if (m_if.tvalid && m_if.tready) begin
                check_eq($sformatf("data[%0d]", out_idx), m_if.tdata, exp_data[out_idx]);
                check_eq($sformatf("last[%0d]", out_idx), m_if.tlast, exp_last[out_idx]);
                check_eq($sformatf("user[%0d]", out_idx), m_if.tuser, exp_user[out_idx]);
                check_eq($sformatf("done[%0d]", out_idx), ap_done, (out_idx == N - 1));
                out_idx++;
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            held       = {m_if.tuser, m_if.tlast, m_if.tdata};
            if (rst_at >= 0 && out_idx == rst_at) begin
                #2 rstn = 1'b0;
                #1 check_reset_outputs("async_rst");
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check_eq("rst_no_done", ap_done, 0);
                end
                rstn = 1'b1; ap_start = 1'b0; s_if.tvalid = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        ap_start = 1'b0;
        check_eq("out_count", out_idx, N);
        check_eq("in_count", in_idx, NI);
        check_eq("done_pulses", dones, 1);
        if (chk_lat) begin
            check_eq("first_latency", first, 2);
            check_eq("frame_cycles", done_cyc, N + 1);
        end
        s_if.tvalid = 1'b0;
        #1;
        check_eq("idle_ready", ap_ready, 1);
        check_eq("idle_tvalid", m_if.tvalid, 0);
        check_eq("idle_stready", s_if.tready, 0);
    endtask

    initial begin
        rstn = 1'b0; ap_start = 1'b0; crop_x0 = '0; crop_y0 = '0; pad_value = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NI; i++) in_pix[i] = PW'(i + 1);
        run_frame(1, 1, '0, 0, 0, -1, 0, -1, 1);
        run_frame(3, 3, '0, 0, 0, -1, 0, -1, 1);
        run_frame(1, 1, '0, 1, 0, -1, 0, -1, 0);
        run_frame(1, 1, '0, 0, 0, 1, 0, -1, 0);

        for (int i = 0; i < NI; i++) in_pix[i] = PW'($urandom);
        run_frame(0, 2, PW'($urandom), 0, 0, -1, 1, -1, 0);
        run_frame(1, 1, PW'($urandom), 0, 0, -1, 0, 7, 0);
        run_frame(2, 0, PW'($urandom), 0, 0, -1, 0, -1, 1);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NI; i++) in_pix[i] = PW'($urandom);
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      PW'($urandom), 1, 1, -1, 0, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uncrop_pad.md
# uncrop_pad

Inverse of the crop stage. Consumes a streamed CROP_ROWS x CROP_COLS image and emits a full FRAME_ROWS x FRAME_COLS raster-order stream. The input image is placed at (crop_y0, crop_x0) and every other pixel is filled with pad_value. It sits on the return path, re-embedding processed crops into a full-size frame for display or DMA. It owns its own row/column counters and uses the same ap_start/ap_done/ap_ready control style as the crop path.

## Interface
Parameters:
- PIXEL_BIT_WIDTH, 10, pixel width
- CROP_ROWS, 10, rows of input (cropped) image
- CROP_COLS, 10, columns of input image
- FRAME_ROWS, 20, rows of output frame; must be ≥ CROP_ROWS
- FRAME_COLS, 20, columns of output frame; must be ≥ CROP_COLS

Ports:
- clk  in  1  single clock
- s_axis_resetn  in  1  reset: asynchronous, active-low
- ap_start  in  1  start one frame; sampled only in IDLE
- ap_ready  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse when last frame pixel is accepted downstream
- crop_x0  in  $clog2(FRAME_COLS)  left column of placement; latched on ap_start
- crop_y0  in  $clog2(FRAME_ROWS)  top row of placement; latched on ap_start
- pad_value  in  PIXEL_BIT_WIDTH  fill pixel; latched on ap_start
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input pixel accepted
- s_axis_tdata  in  PIXEL_BIT_WIDTH  input pixel
- m_axis_tvalid  out  1  output pixel valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  PIXEL_BIT_WIDTH  output pixel
- m_axis_tlast  out  1  last pixel of each output row
- m_axis_tuser  out  1  first pixel of frame (row 0, col 0)

## Operation
- FSM states:
  - IDLE: ap_ready=1. ap_start latches crop_x0, crop_y0 and pad_value, clears the row/col counters, and moves to RUN.
  - RUN: emits FRAME_ROWS*FRAME_COLS pixels in raster order. Moves to IDLE on the cycle the last pixel handshakes; ap_done pulses that cycle.
- Placement clamp at latch time: x0 = min(crop_x0, FRAME_COLS-CROP_COLS); y0 = min(crop_y0, FRAME_ROWS-CROP_ROWS).
- Window test: inside = (row ≥ y0) && (row < y0+CROP_ROWS) && (col ≥ x0) && (col < x0+CROP_COLS). Compute all sums at width+1 so nothing wraps.
- Output register is one stage. It may load when empty, or when m_axis_tvalid && m_axis_tready in the same cycle.
  - If inside: load requires s_axis_tvalid. s_axis_tready = RUN && inside && load_allowed. Load s_axis_tdata.
  - If outside: load pad_value unconditionally when load allowed. s_axis_tready = 0.
- The col/row counters advance on each load. col wraps at FRAME_COLS-1 to 0 and increments row. The last load of the frame stops further loads.
- tlast = (col == FRAME_COLS-1) and tuser = (row == 0 && col == 0). Both are registered alongside tdata.
- Input beats beyond CROP_ROWS*CROP_COLS are never accepted, because tready is 0 outside the window and in IDLE.
- ap_start in RUN is ignored. Latched parameters are stable for the whole frame.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, ap_done=0, ap_ready=1, s_axis_tready=0, FSM=IDLE, counters=0.
- Latency:
  - ap_start to first m_axis_tvalid: 2 cycles (latch, then load).
  - Input handshake to output valid: 1 cycle.
- Throughput: 1 pixel/cycle with m_axis_tready=1 and no input starvation. A frame takes FRAME_ROWS*FRAME_COLS cycles plus 1.
- Backpressure: m_axis_tdata, tlast and tuser hold stable while tvalid && !tready. s_axis_tready drops in the same cycle.
- Starvation inside the window: a bubble is allowed and tvalid drops after the pending beat drains. Pad pixels are never emitted out of order.
- Asynchronous reset mid-frame abandons the frame, applies the reset values immediately, and emits no ap_done.
- ap_done and ap_ready=1 coincide with the final handshake cycle. ap_start is accepted on the following cycle.

## Structure
- Shared package crop_pkg holds:
  - the state enum (IDLE, RUN);
  - coordinate width localparams derived from FRAME_ROWS and FRAME_COLS;
  - a clamp function.
- One sub-module, pixel_coord_counter: a parameterised raster row/col counter with advance, clear, end-of-row and end-of-frame flags. The crop path can reuse it to generate its row/col counts.

## Test plan
- Frame 4x4, crop 2x2, x0=1, y0=1, pad=0, input 1,2,3,4, m_tready=1 -> output 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0. tlast on pixels 3,7,11,15; tuser on pixel 0; ap_done on the 16th handshake.
- Same setup with crop_x0=3, crop_y0=3 -> clamped to (2,2). Input lands at bottom-right: rows 2–3, cols 2–3.
- Random m_axis_tready at 50% -> data, tlast and tuser stable under stall. Output sequence identical to the first case; no beats dropped or duplicated.
- s_axis_tvalid held low for 5 cycles before pixel 2 -> output pauses, resumes in order, and the total output count stays 16.
- ap_start pulsed mid-frame with different x0 -> ignored and the frame is unchanged. Reset asserted at pixel 7 -> outputs go to reset values at once and no ap_done. A new ap_start after release produces a full correct frame.
